// File: rtl/argmax_row_streamer.sv
// argmax_row_streamer: buffers a FEATURE_ROWS x WEIGHT_COLS word array and streams it one row per cycle; optional consumer stall under ARGMAX_STREAM_STALL_EN
module argmax_row_streamer #(
    parameter int WEIGHT_COLS    = 3,
    parameter int FEATURE_ROWS   = 6,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int ROW_CNT_WIDTH  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ROW_CNT_WIDTH-1:0]  wr_row,
    input  logic [1:0]                wr_col,
    input  logic [DOT_PROD_WIDTH-1:0] wr_data,
    input  logic                      start,
    input  logic                      stall,
    output logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_row [0:WEIGHT_COLS-1],
    output logic                      enable_read_calc_save,
    output logic [ROW_CNT_WIDTH-1:0]  argmax_row_count,
    output logic                      busy,
    output logic                      done,
    output logic                      wr_err
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    logic [1:0]                state_q, state_d;
    logic [DOT_PROD_WIDTH-1:0] mem_q [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] row_q [0:WEIGHT_COLS-1];
    logic [DOT_PROD_WIDTH-1:0] row_d [0:WEIGHT_COLS-1];
    logic [ROW_CNT_WIDTH-1:0]  cnt_q, cnt_d, nxt;
    logic                      en_q, en_d, done_q, done_d, err_q, err_d;
    logic                      wr_ok, hold;
`ifdef ARGMAX_STREAM_STALL_EN
    assign hold = stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign hold = 1'b0;
`endif
    assign nxt                   = cnt_q + ROW_CNT_WIDTH'(1);
    assign wr_ok                 = wr_en && state_q == IDLE && 32'(wr_row) < FEATURE_ROWS && 32'(wr_col) < WEIGHT_COLS;
    assign busy                  = state_q != IDLE;
    assign adj_fm_wm_row         = row_q;
    assign enable_read_calc_save = en_q;
    assign argmax_row_count      = cnt_q;
    assign done                  = done_q;
    assign wr_err                = err_q;
    // next-state: launch a pass from IDLE, advance one row per unstalled cycle, retire through DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = wr_en && !wr_ok;
        if (state_q == IDLE && start) begin
            state_d = STREAM;
            cnt_d   = '0;
            row_d   = mem_q[0];
            en_d    = 1'b1;
        end else if (state_q == STREAM && !hold) begin
            if (cnt_q == ROW_CNT_WIDTH'(FEATURE_ROWS - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                cnt_d = nxt;
                row_d = mem_q[nxt];
                en_d  = 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // state, output registers and buffer; reset clears everything including the array
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < WEIGHT_COLS; k++) row_q[k] <= '0;
            for (int r = 0; r < FEATURE_ROWS; r++)
                for (int k = 0; k < WEIGHT_COLS; k++) mem_q[r][k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            row_q   <= row_d;
            if (wr_ok) mem_q[wr_row][wr_col] <= wr_data;
        end
    end
endmodule

// File: tb/tb_argmax_row_streamer.sv
// tb_argmax_row_streamer: directed checks of fill, streaming, write errors, same-cycle write/start, stall and async reset
module tb_argmax_row_streamer;
    logic        clk = 1'b0;
    logic        reset, wr_en, start, stall;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [15:0] wr_data;
    logic [15:0] adj_fm_wm_row [0:2];
    logic        enable_read_calc_save, busy, done, wr_err;
    logic [2:0]  argmax_row_count;
    int          vecs = 0;
    int          errs = 0;
    int          dones;

    argmax_row_streamer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .stall(stall), .adj_fm_wm_row(adj_fm_wm_row),
        .enable_read_calc_save(enable_read_calc_save), .argmax_row_count(argmax_row_count),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rowv();
        return {adj_fm_wm_row[0], adj_fm_wm_row[1], adj_fm_wm_row[2]};
    endfunction

    function automatic logic [47:0] erow(input int r);
        return {16'(16 * r), 16'(16 * r + 1), 16'(16 * r + 2)};
    endfunction

    task automatic wr(input int r, input int c, input logic [15:0] d);
        wr_en = 1'b1;
        wr_row = 3'(r);
        wr_col = 2'(c);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; start = 1'b0; stall = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        #12;
        chk("rst_row", 64'(rowv()), 64'(0));
        chk("rst_ctl", {59'(0), enable_read_calc_save, busy, done, wr_err, 1'b0}, 64'(0));
        chk("rst_cnt", 64'(argmax_row_count), 64'(0));
        step();
        reset = 1'b0;
        step();
        // fill array with 16*r+k
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 3; k++) wr(r, k, 16'(16 * r + k));
        step();
        chk("fill_no_err", 64'(wr_err), 64'(0));
        // full pass, rows on consecutive cycles
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p1_en0", 64'(enable_read_calc_save), 64'(1));
        chk("p1_cnt0", 64'(argmax_row_count), 64'(0));
        chk("p1_row0", 64'(rowv()), 64'(erow(0)));
        chk("p1_busy", 64'(busy), 64'(1));
        for (int i = 1; i < 6; i++) begin
            step();
            chk("p1_cnt", 64'(argmax_row_count), 64'(i));
            chk("p1_row", 64'(rowv()), 64'(erow(i)));
            chk("p1_en", 64'(enable_read_calc_save), 64'(1));
            chk("p1_nodone", 64'(done), 64'(0));
        end
        step();
        chk("p1_done", 64'(done), 64'(1));
        chk("p1_done_en", 64'(enable_read_calc_save), 64'(0));
        chk("p1_done_busy", 64'(busy), 64'(1));
        chk("p1_hold_cnt", 64'(argmax_row_count), 64'(5));
        chk("p1_hold_row", 64'(rowv()), 64'(erow(5)));
        step();
        chk("p1_idle_busy", 64'(busy), 64'(0));
        chk("p1_idle_done", 64'(done), 64'(0));
        // out-of-range writes
        wr(6, 0, 16'hDEAD);
        chk("oor_row_err", 64'(wr_err), 64'(1));
        step();
        chk("oor_err_pulse", 64'(wr_err), 64'(0));
        wr(0, 3, 16'hBEEF);
        chk("oor_col_err", 64'(wr_err), 64'(1));
        // write and restart during STREAM, start during DONE
        start = 1'b1;
        step();
        chk("b_row0", 64'(rowv()), 64'(erow(0)));
        wr_en = 1'b1; wr_row = 3'd1; wr_col = 2'd1; wr_data = 16'hAAAA;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("b_wr_err", 64'(wr_err), 64'(1));
        chk("b_no_restart", 64'(argmax_row_count), 64'(1));
        chk("b_row1_kept", 64'(rowv()), 64'(erow(1)));
        for (int i = 2; i < 6; i++) step();
        chk("b_cnt5", 64'(argmax_row_count), 64'(5));
        step();
        chk("b_done", 64'(done), 64'(1));
        start = 1'b1;
        step();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            step();
        end
        chk("b_single_done", 64'(dones), 64'(0));
        chk("b_done_start_ignored", 64'(busy), 64'(0));
        // same-cycle write and start: no bypass
        wr_en = 1'b1; wr_row = 3'd0; wr_col = 2'd0; wr_data = 16'hFFFF; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        chk("sc_err", 64'(wr_err), 64'(0));
        chk("sc_row0_old", 64'(rowv()), 64'(erow(0)));
        for (int i = 0; i < 7; i++) step();
        chk("sc_idle", 64'(busy), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sc_row0_new", 64'(rowv()), {16'(0), 48'h0000FFFF_0001_0002} >> 0 & 64'h0000FFFF00010002);
        for (int i = 0; i < 7; i++) step();
        // stall while row 1 presented
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("st_row1", 64'(argmax_row_count), 64'(1));
        stall = 1'b1;
        step();
`ifdef ARGMAX_STREAM_STALL_EN
        chk("st_en_lo1", 64'(enable_read_calc_save), 64'(0));
        chk("st_hold_cnt", 64'(argmax_row_count), 64'(1));
        chk("st_hold_row", 64'(rowv()), 64'(erow(1)));
        step();
        stall = 1'b0;
        chk("st_en_lo2", 64'(enable_read_calc_save), 64'(0));
        step();
        chk("st_row2", 64'(rowv()), 64'(erow(2)));
        chk("st_en2", 64'(enable_read_calc_save), 64'(1));
        for (int i = 3; i < 6; i++) step();
        chk("st_cnt5", 64'(argmax_row_count), 64'(5));
        step();
        chk("st_done_c9", 64'(done), 64'(1));
`else
        stall = 1'b0;
        chk("st_ignored_cnt", 64'(argmax_row_count), 64'(2));
        chk("st_ignored_en", 64'(enable_read_calc_save), 64'(1));
        for (int i = 3; i < 6; i++) step();
        step();
        chk("st_done_c7", 64'(done), 64'(1));
`endif
        step();
        step();
        // async reset during row 3
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 4; i++) step();
        chk("r_cnt3", 64'(argmax_row_count), 64'(3));
        #2;
        reset = 1'b1;
        #1;
        chk("r_async_row", 64'(rowv()), 64'(0));
        chk("r_async_ctl", {60'(0), enable_read_calc_save, busy, done, wr_err}, 64'(0));
        chk("r_async_cnt", 64'(argmax_row_count), 64'(0));
        step();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            step();
        end
        chk("r_no_done", 64'(dones), 64'(0));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("r_cleared_row2", 64'(rowv()), 64'(0));
        chk("r_cleared_cnt", 64'(argmax_row_count), 64'(2));
        for (int i = 0; i < 6; i++) step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
